// File: rtl/axi_write_arbiter.sv
// rtl/axi_write_arbiter.sv - two-master round-robin write arbiter onto a single AXI write slave
module axi_write_arbiter #(
  parameter int BUSWIDTH = 32
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  // requester 0
  input  logic [3:0]          m0_AWID,
  input  logic [31:0]         m0_AWADDR,
  input  logic [3:0]          m0_AWLEN,
  input  logic [2:0]          m0_AWSIZE,
  input  logic [1:0]          m0_AWBURST,
  input  logic                m0_AWVALID,
  output logic                m0_AWREADY,
  input  logic [BUSWIDTH-1:0] m0_WDATA,
  input  logic [3:0]          m0_WSTRB,
  input  logic                m0_WLAST,
  input  logic                m0_WVALID,
  output logic                m0_WREADY,
  output logic [3:0]          m0_BID,
  output logic [1:0]          m0_BRESP,
  output logic                m0_BVALID,
  input  logic                m0_BREADY,
  // requester 1
  input  logic [3:0]          m1_AWID,
  input  logic [31:0]         m1_AWADDR,
  input  logic [3:0]          m1_AWLEN,
  input  logic [2:0]          m1_AWSIZE,
  input  logic [1:0]          m1_AWBURST,
  input  logic                m1_AWVALID,
  output logic                m1_AWREADY,
  input  logic [BUSWIDTH-1:0] m1_WDATA,
  input  logic [3:0]          m1_WSTRB,
  input  logic                m1_WLAST,
  input  logic                m1_WVALID,
  output logic                m1_WREADY,
  output logic [3:0]          m1_BID,
  output logic [1:0]          m1_BRESP,
  output logic                m1_BVALID,
  input  logic                m1_BREADY,
  // shared slave
  output logic [3:0]          s_AWID,
  output logic [31:0]         s_AWADDR,
  output logic [3:0]          s_AWLEN,
  output logic [2:0]          s_AWSIZE,
  output logic [1:0]          s_AWBURST,
  output logic                s_AWVALID,
  input  logic                s_AWREADY,
  output logic [BUSWIDTH-1:0] s_WDATA,
  output logic [3:0]          s_WSTRB,
  output logic                s_WLAST,
  output logic                s_WVALID,
  input  logic                s_WREADY,
  input  logic [3:0]          s_BID,
  input  logic [1:0]          s_BRESP,
  input  logic                s_BVALID,
  output logic                s_BREADY,
  // status
  output logic [1:0]          grant,
  output logic                len_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t     state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_owner_q, last_owner_d;
  logic [3:0] beat_cnt_q, beat_cnt_d;
  logic [3:0] awlen_q, awlen_d;
  logic       len_err_q, len_err_d;

  logic in_addr, in_data, in_resp;
  assign in_addr = (state_q == ADDR);
  assign in_data = (state_q == DATA);
  assign in_resp = (state_q == RESP);

  // Payload fields follow the owner; only the valid/ready qualifiers are state-gated.
  assign s_AWID    = owner_q ? m1_AWID    : m0_AWID;
  assign s_AWADDR  = owner_q ? m1_AWADDR  : m0_AWADDR;
  assign s_AWLEN   = owner_q ? m1_AWLEN   : m0_AWLEN;
  assign s_AWSIZE  = owner_q ? m1_AWSIZE  : m0_AWSIZE;
  assign s_AWBURST = owner_q ? m1_AWBURST : m0_AWBURST;
  assign s_AWVALID = in_addr && (owner_q ? m1_AWVALID : m0_AWVALID);

  assign s_WDATA   = owner_q ? m1_WDATA : m0_WDATA;
  assign s_WSTRB   = owner_q ? m1_WSTRB : m0_WSTRB;
  assign s_WLAST   = owner_q ? m1_WLAST : m0_WLAST;
  assign s_WVALID  = in_data && (owner_q ? m1_WVALID : m0_WVALID);

  assign s_BREADY  = in_resp && (owner_q ? m1_BREADY : m0_BREADY);

  assign m0_AWREADY = in_addr && !owner_q && s_AWREADY;
  assign m1_AWREADY = in_addr &&  owner_q && s_AWREADY;
  assign m0_WREADY  = in_data && !owner_q && s_WREADY;
  assign m1_WREADY  = in_data &&  owner_q && s_WREADY;
  assign m0_BVALID  = in_resp && !owner_q && s_BVALID;
  assign m1_BVALID  = in_resp &&  owner_q && s_BVALID;
  assign m0_BID     = s_BID;
  assign m1_BID     = s_BID;
  assign m0_BRESP   = s_BRESP;
  assign m1_BRESP   = s_BRESP;

  assign grant   = (state_q == IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);
  assign len_err = len_err_q;

  // State register; last_owner resets to 1 so that M0 wins the first tie.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      beat_cnt_q   <= 4'd0;
      awlen_q      <= 4'd0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
      awlen_q      <= awlen_d;
      len_err_q    <= len_err_d;
    end
  end

  // Next-state: arbitrate in IDLE, then track one transaction through AW, W and B.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    awlen_d      = awlen_q;
    len_err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_AWVALID || m1_AWVALID) begin
          owner_d = (m0_AWVALID && m1_AWVALID) ? ~last_owner_q : m1_AWVALID;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (s_AWVALID && s_AWREADY) begin
          awlen_d    = s_AWLEN;
          beat_cnt_d = 4'd0;
          state_d    = DATA;
        end
      end
      DATA: begin
        if (s_WVALID && s_WREADY) begin
          beat_cnt_d = beat_cnt_q + 4'd1;
          if (s_WLAST) begin
            len_err_d = (beat_cnt_q != awlen_q);
            state_d   = RESP;
          end
        end
      end
      RESP: begin
        if (s_BVALID && s_BREADY) begin
          last_owner_d = owner_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/axi_write_arbiter.md
AXI_WRITE_ARBITER -- requirements
Module: axi_write_arbiter

Interface
REQ-001 SHALL have parameter BUSWIDTH, default 32, giving the WDATA width of every port.
REQ-002 SHALL have port ACLK, input, 1 bit: clock; all state updates on its rising edge.
REQ-003 SHALL have port ARESETn, input, 1 bit: reset, synchronous, active-low; clock ACLK.
REQ-004 SHALL have ports mN_AWID[3:0], mN_AWADDR[31:0], mN_AWLEN[3:0], mN_AWSIZE[2:0] and mN_AWBURST[1:0], all inputs, for N=0,1: requester write-address fields.
REQ-005 SHALL have ports mN_AWVALID (input, 1) and mN_AWREADY (output, 1), N=0,1: requester address handshake.
REQ-006 SHALL have ports mN_WDATA[BUSWIDTH-1:0], mN_WSTRB[3:0], mN_WLAST and mN_WVALID, all inputs, and mN_WREADY, output, N=0,1: requester write data.
REQ-007 SHALL have ports mN_BID[3:0], mN_BRESP[1:0] and mN_BVALID, all outputs, and mN_BREADY, input, N=0,1: requester write response.
REQ-008 SHALL have ports s_AW* (outputs, same widths as REQ-004/005) and s_AWREADY (input): shared write-slave address channel.
REQ-009 SHALL have ports s_W* (outputs, same widths as REQ-006) and s_WREADY (input): shared write-slave data channel.
REQ-010 SHALL have ports s_BID[3:0], s_BRESP[1:0] and s_BVALID (inputs) and s_BREADY (output): shared write-slave response channel.
REQ-011 SHALL have port grant[1:0], output: one-hot owner of the slave; 00 when idle.
REQ-012 SHALL have port len_err, output, 1 bit: one-cycle pulse flagging a burst-length mismatch.

Function
REQ-013 SHALL implement a registered FSM with states IDLE, ADDR, DATA and RESP; only one write transaction SHALL be in flight at a time.
REQ-014 IDLE: if exactly one mN_AWVALID=1, SHALL latch owner=N and go to ADDR the next cycle; if both are 1, SHALL pick the master that is not last_owner (round-robin); if neither, SHALL stay in IDLE.
REQ-015 In IDLE, all s_*VALID, s_BREADY, mN_AWREADY, mN_WREADY and mN_BVALID SHALL be 0.
REQ-016 ADDR: SHALL route the owner's AW fields and AWVALID combinationally to s_AW*; SHALL drive owner AWREADY = s_AWREADY; on s_AWVALID&&s_AWREADY SHALL latch AWLEN, clear beat_cnt and go to DATA.
REQ-017 DATA: SHALL route the owner's W fields and WVALID to s_W*; SHALL drive owner WREADY = s_WREADY; each W handshake SHALL increment beat_cnt (4-bit, wraps at 15).
REQ-018 DATA: a handshake with WLAST=1 SHALL move the FSM to RESP; if beat_cnt != latched AWLEN at that beat, SHALL pulse len_err for exactly 1 cycle.
REQ-019 RESP: SHALL route s_B* to the owner's B outputs and the owner's BREADY to s_BREADY; on s_BVALID&&s_BREADY SHALL set last_owner=owner, clear grant and return to IDLE.
REQ-020 The non-owner's AWREADY, WREADY and BVALID SHALL be 0 in every state; its requests SHALL wait without loss.
REQ-021 grant SHALL equal one-hot(owner) in ADDR, DATA and RESP, and 00 in IDLE.
REQ-022 Master AWVALID changes after the grant decision SHALL NOT change owner until return to IDLE.
REQ-023 Minimum transaction latency SHALL be: 1 arbitration cycle + AW handshake + (AWLEN+1) beats + B handshake; IDLE-to-regrant SHALL take 1 cycle.

Reset
REQ-024 While ARESETn=0 at a rising edge: state=IDLE, owner=0, last_owner=1 (M0 wins first tie), beat_cnt=0, latched AWLEN=0, len_err=0, grant=00.
REQ-025 Reset asserted mid-transaction SHALL abort it; from the following cycle all outputs SHALL take the IDLE values of REQ-015 and REQ-021.

Verification
REQ-026 Single request: m0 AWADDR=0x100, AWLEN=3, 4 beats, BRESP=00 -> grant=01, slave sees addr 0x100 and 4 beats, m0 gets BVALID; back to IDLE, len_err=0.
REQ-027 Tie: both AWVALID=1 after reset -> M0 served first, M1 second (grant 01 then 10); repeat tie -> M0 again.
REQ-028 Stall: s_WREADY held 0 for 5 cycles in DATA -> m0_WREADY=0 and beat_cnt frozen; m1_WREADY=0 throughout.
REQ-029 Length error: AWLEN=3 but WLAST on beat 2 -> len_err pulses 1 cycle and FSM still reaches RESP.
REQ-030 Reset in DATA after beat 1 -> next cycle grant=00, all valid/ready outputs 0; a new m1 request is granted normally.
